// File: rtl/led_scan_driver_pkg.sv
// Shared definitions for the digital clock's display path.
//   LED_BLANK_CODE : decoder input that renders a dark digit
//   BCD_MAX        : largest digit value the decoder shows as a numeral
//   scan_state_e   : scan FSM states (IDLE, BLANK, SHOW)
package led_scan_driver_pkg;

  localparam logic [7:0] LED_BLANK_CODE = 8'hFF;
  localparam logic [3:0] BCD_MAX        = 4'd9;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_BLANK = 2'd1,
    SCAN_SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/led_scan_driver_scan_slot_timer.sv
// Scan slot timer: modulo-SCAN_DIV counter that paces one digit slot.
//   clk, rst_n : clock, synchronous active-low reset
//   run        : count while high, hold at zero while low
//   blank_done : high on the last cycle of the dark gap (never if BLANK_CYCLES=0)
//   slot_end   : high on the last cycle of the slot
module led_scan_driver_scan_slot_timer #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_done,
  output logic slot_end
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !run)  cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign slot_end   = run && (cnt == LAST);
  assign blank_done = run && (BLANK_CYCLES != 0) && (cnt == BLAST);

endmodule

// File: rtl/led_scan_driver.sv
// Multiplexed 7-segment scan driver. Walks one digit per SCAN_DIV-cycle slot,
// feeding the decoder's binary input and the active-low digit selects. Digits
// and masks are captured once per frame so a frame never tears.
//   clk, rst_n  : clock, synchronous active-low reset
//   En          : scan enable, low forces idle/dark
//   DigitsIn    : packed BCD digits, digit 0 in the low nibble
//   DotMask     : decimal point request per digit
//   BlinkMask   : digits subject to blinking
//   BlinkPhase  : live blink level, 1 = blinking digits dark
//   BinData     : decoder input (8'hFF = blank)
//   DigSel      : active-low digit enables, at most one low
//   DotOut      : decimal point of the selected digit
//   FrameStart  : one-cycle pulse as slot 0 begins
module led_scan_driver
  import led_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    En,
  input  logic [4*NUM_DIGITS-1:0] DigitsIn,
  input  logic [NUM_DIGITS-1:0]   DotMask,
  input  logic [NUM_DIGITS-1:0]   BlinkMask,
  input  logic                    BlinkPhase,
  output logic [7:0]              BinData,
  output logic [NUM_DIGITS-1:0]   DigSel,
  output logic                    DotOut,
  output logic                    FrameStart
);

  localparam logic [1:0] IDLE  = 2'(SCAN_IDLE);
  localparam logic [1:0] BLANK = 2'(SCAN_BLANK);
  localparam logic [1:0] SHOW  = 2'(SCAN_SHOW);
  // With no dark gap a slot starts straight in SHOW.
  localparam logic [1:0] SLOT_FIRST = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [1:0]              state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [4*NUM_DIGITS-1:0] snap_dig, dig_n;
  logic [NUM_DIGITS-1:0]   snap_dot, dot_n, snap_blink, blink_n;
  logic                    fs_n;
  logic                    blank_done, slot_end;

  logic [7:0]            bin_n;
  logic [NUM_DIGITS-1:0] sel_n;
  logic                  dotout_n;
  logic [3:0]            digit;
  logic                  blinked;

  led_scan_driver_scan_slot_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       ((state != IDLE) && En),
    .blank_done(blank_done),
    .slot_end  (slot_end)
  );

  // Next FSM state, index and snapshot. The snapshot is only reloaded at a
  // frame start, which is what keeps a frame coherent.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dig_n   = snap_dig;
    dot_n   = snap_dot;
    blink_n = snap_blink;
    fs_n    = 1'b0;
    if (!En) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SLOT_FIRST;
          idx_n   = '0;
          fs_n    = 1'b1;
        end
        BLANK: if (blank_done) state_n = SHOW;
        SHOW: if (slot_end) begin
          state_n = SLOT_FIRST;
          if (idx == LAST_IDX) begin
            idx_n = '0;
            fs_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      if (fs_n) begin
        dig_n   = DigitsIn;
        dot_n   = DotMask;
        blink_n = BlinkMask;
      end
    end
  end

  // Outputs are derived from the next state so that the registered outputs
  // line up with the state they describe.
  always_comb begin
    digit    = dig_n[4*idx_n +: 4];
    blinked  = blink_n[idx_n] && BlinkPhase;
    bin_n    = (blinked || digit > BCD_MAX) ? LED_BLANK_CODE : {4'b0, digit};
    sel_n    = '1;
    dotout_n = 1'b0;
    if (state_n == IDLE) begin
      bin_n = LED_BLANK_CODE;
    end else if (state_n == SHOW) begin
      sel_n[idx_n] = 1'b0;
      dotout_n     = dot_n[idx_n] && !blinked;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      snap_dig   <= '0;
      snap_dot   <= '0;
      snap_blink <= '0;
      BinData    <= LED_BLANK_CODE;
      DigSel     <= '1;
      DotOut     <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      snap_dig   <= dig_n;
      snap_dot   <= dot_n;
      snap_blink <= blink_n;
      BinData    <= bin_n;
      DigSel     <= sel_n;
      DotOut     <= dotout_n;
      FrameStart <= fs_n;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
module tb_led_scan_driver;
  localparam int N  = 8;
  localparam int SD = 10;

  logic clk = 1'b0;
  logic rst_n, En, BlinkPhase;
  logic [4*N-1:0] DigitsIn;
  logic [N-1:0] DotMask, BlinkMask;
  logic [7:0] bin_a, bin_b;
  logic [N-1:0] sel_a, sel_b;
  logic dot_a, dot_b, fs_a, fs_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .En(En), .DigitsIn(DigitsIn), .DotMask(DotMask),
    .BlinkMask(BlinkMask), .BlinkPhase(BlinkPhase), .BinData(bin_a),
    .DigSel(sel_a), .DotOut(dot_a), .FrameStart(fs_a));

  led_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .En(En), .DigitsIn(DigitsIn), .DotMask(DotMask),
    .BlinkMask(BlinkMask), .BlinkPhase(BlinkPhase), .BinData(bin_b),
    .DigSel(sel_b), .DotOut(dot_b), .FrameStart(fs_b));

  // Model: time since frame start plus a per-frame copy of the inputs.
  logic       m_valid = 1'b0, m_active = 1'b0, m_phase = 1'b0;
  int         m_t = 0;
  logic [3:0] m_dig [N];
  logic [N-1:0] m_dot, m_blink;

  task automatic m_snap();
    for (int i = 0; i < N; i++) m_dig[i] = DigitsIn[4*i +: 4];
    m_dot   = DotMask;
    m_blink = BlinkMask;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1; m_active = 1'b0; m_t = 0;
    end else if (!En) begin
      m_active = 1'b0; m_t = 0;
    end else if (!m_active) begin
      m_active = 1'b1; m_t = 0; m_snap();
    end else begin
      m_t++;
      if (m_t == N*SD) begin m_t = 0; m_snap(); end
    end
    m_phase = BlinkPhase;
  end

  task automatic cmp(string nm, int blank, logic [7:0] bin, logic [N-1:0] sel,
                     logic dot, logic fs);
    logic [7:0] e_bin; logic [N-1:0] e_sel; logic e_dot, e_fs, blk;
    int slot;
    e_bin = 8'hFF; e_sel = '1; e_dot = 1'b0; e_fs = 1'b0;
    if (m_active) begin
      slot  = m_t / SD;
      blk   = m_blink[slot] && m_phase;
      e_bin = (blk || m_dig[slot] > 4'd9) ? 8'hFF : {4'b0, m_dig[slot]};
      e_fs  = (m_t == 0);
      if ((m_t % SD) >= blank) begin
        e_sel[slot] = 1'b0;
        e_dot = m_dot[slot] && !blk;
      end
    end
    n_checks++;
    if (bin !== e_bin || sel !== e_sel || dot !== e_dot || fs !== e_fs) begin
      n_fail++;
      $display("FAIL %s t=%0d got bin=%h sel=%h dot=%b fs=%b expected bin=%h sel=%h dot=%b fs=%b",
               nm, m_t, bin, sel, dot, fs, e_bin, e_sel, e_dot, e_fs);
    end
  endtask

  always @(negedge clk) if (m_valid) begin
    cmp("model_a", 2, bin_a, sel_a, dot_a, fs_a);
    cmp("model_b", 0, bin_b, sel_b, dot_b, fs_b);
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to the next negedge where the frame time equals k.
  task automatic at_t(int k);
    logic hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = m_active && (m_t == k);
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL at_t timeout waiting for t=%0d", k);
    end
  endtask

  initial begin
    rst_n = 1'b0; En = 1'b1; BlinkPhase = 1'b0;
    DigitsIn = 32'h12345678; DotMask = '0; BlinkMask = '0;
    repeat (3) @(negedge clk);
    chk("rst_bin", bin_a, 8'hFF);
    chk("rst_sel", sel_a, 8'hFF);
    chk("rst_fs", {7'b0, fs_a}, 8'h00);
    rst_n = 1'b1;

    // Frame 1: basic scan
    at_t(0);
    chk("f1_fs", {7'b0, fs_a}, 8'h01);
    chk("f1_t0_sel_a", sel_a, 8'hFF);
    chk("f1_t0_bin_a", bin_a, 8'h08);
    chk("f1_t0_sel_b", sel_b, 8'hFE);
    at_t(1);  chk("f1_t1_fs", {7'b0, fs_a}, 8'h00);
    at_t(2);  chk("f1_t2_sel", sel_a, 8'hFE); chk("f1_t2_bin", bin_a, 8'h08);
    at_t(9);  chk("f1_t9_sel", sel_a, 8'hFE);
    at_t(10); chk("f1_t10_sel_a", sel_a, 8'hFF); chk("f1_t10_bin", bin_a, 8'h07);
              chk("f1_t10_sel_b", sel_b, 8'hFD);
    at_t(72); chk("f1_t72_sel", sel_a, 8'h7F); chk("f1_t72_bin", bin_a, 8'h01);

    // Frame 2: mid-frame input change must not tear
    at_t(0);  chk("f2_fs", {7'b0, fs_a}, 8'h01);
    at_t(35); DigitsIn = 32'h99999999;
    at_t(42); chk("f2_slot4", bin_a, 8'h04);
    at_t(75); chk("f2_slot7", bin_a, 8'h01);
    at_t(2);  chk("f3_slot0", bin_a, 8'h09);

    // Frame 3 loads masks and a non-BCD digit for frame 4
    at_t(5);
    DigitsIn = 32'h1234C678; BlinkMask = 8'h03; DotMask = 8'h05; BlinkPhase = 1'b1;
    at_t(12); chk("f3_noblink", bin_a, 8'h09); chk("f3_nodot", {7'b0, dot_a}, 8'h00);
    at_t(2);  chk("f4_s0_bin", bin_a, 8'hFF); chk("f4_s0_dot", {7'b0, dot_a}, 8'h00);
              chk("f4_s0_sel", sel_a, 8'hFE);
    at_t(12); chk("f4_s1_bin", bin_a, 8'hFF); chk("f4_s1_sel", sel_a, 8'hFD);
    at_t(22); chk("f4_s2_bin", bin_a, 8'h06); chk("f4_s2_dot", {7'b0, dot_a}, 8'h01);
              chk("f4_s2_sel", sel_a, 8'hFB);
    at_t(32); chk("f4_s3_nonbcd", bin_a, 8'hFF); chk("f4_s3_sel", sel_a, 8'hF7);
    at_t(35); BlinkPhase = 1'b0;
    at_t(2);  chk("f5_s0_bin", bin_a, 8'h08);
    at_t(12); chk("f5_s1_bin", bin_a, 8'h07);

    // En drop mid-SHOW in slot 5
    at_t(55); En = 1'b0;
    @(negedge clk);
    chk("endrop_sel", sel_a, 8'hFF); chk("endrop_bin", bin_a, 8'hFF);
    chk("endrop_dot", {7'b0, dot_a}, 8'h00); chk("endrop_sel_b", sel_b, 8'hFF);
    repeat (3) @(negedge clk);
    En = 1'b1;
    @(negedge clk);
    chk("enrise_fs", {7'b0, fs_a}, 8'h01); chk("enrise_bin", bin_a, 8'h08);
    chk("enrise_sel_a", sel_a, 8'hFF); chk("enrise_sel_b", sel_b, 8'hFE);

    // Reset mid-slot
    at_t(23); rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sel", sel_a, 8'hFF); chk("midrst_bin", bin_a, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_fs", {7'b0, fs_a}, 8'h01);
    at_t(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
